// File: rtl/op_drain_pkg.sv
// Shared types and helpers for the output-URAM drain engine.
// Holds the FSM state encoding, default widths and the beat-count helper.
package op_drain_pkg;

    localparam int DEF_RESULT_WIDTH = 16;
    localparam int DEF_AXIS_WIDTH   = 2 * DEF_RESULT_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

    // Two result words per stream beat.
    function automatic int total_beats(input int num_banks, input int words_per_bank);
        return (num_banks * words_per_bank) / 2;
    endfunction

endpackage

// File: rtl/op_drain_fifo.sv
// Result-word FIFO for the drain engine: single push, pair pop, live occupancy count.
// Push and pair-pop in the same cycle are both honoured; the caller guarantees no overflow/underflow.
module op_drain_fifo
    import op_drain_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DEF_RESULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop_pair,
    output logic [WIDTH-1:0]             head0,
    output logic [WIDTH-1:0]             head1,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_p1;

    // Modular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int step);
        int s;
        s = int'(p) + step;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    assign rd_ptr_p1 = wrap_add(rd_ptr, 1);
    assign head0     = mem[rd_ptr];
    assign head1     = mem[rd_ptr_p1];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)     wr_ptr <= wrap_add(wr_ptr, 1);
            if (pop_pair) rd_ptr <= wrap_add(rd_ptr, 2);
            count <= CNT_W'(int'(count) + (push ? 1 : 0) - (pop_pair ? 2 : 0));
        end
    end

endmodule

// File: rtl/op_uram_drain.sv
// Bulk drain of the GEMM output URAM banks into a 32-bit AXI4-Stream toward a DMA.
// Reads are credit-limited against the result FIFO so back-pressure can never overflow it.
module op_uram_drain
    import op_drain_pkg::*;
#(
    parameter int NUM_BANKS       = 64,
    parameter int BANK_ADDR_WIDTH = 14,
    parameter int WORDS_PER_BANK  = 16384,
    parameter int RESULT_WIDTH    = DEF_RESULT_WIDTH,
    parameter int READ_LATENCY    = 2,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_BANKS-1:0]         op_uram_enb,
    output logic [BANK_ADDR_WIDTH-1:0]   op_uram_addrb,
    input  logic [RESULT_WIDTH-1:0]      op_uram_doutb,
    output logic [2*RESULT_WIDTH-1:0]    m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [31:0]                  beats_sent,
    output drain_state_e                 dbg_state
);

    localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int PIPE_N      = READ_LATENCY + 1;
    localparam int TOTAL_BEATS = total_beats(NUM_BANKS, WORDS_PER_BANK);

    if ((NUM_BANKS * WORDS_PER_BANK) % 2 != 0) begin : g_odd_words
        $error("op_uram_drain: NUM_BANKS*WORDS_PER_BANK must be even");
    end
    if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_fifo_small
        $error("op_uram_drain: FIFO_DEPTH must be at least READ_LATENCY+2");
    end
    if (READ_LATENCY < 1) begin : g_lat_zero
        $error("op_uram_drain: READ_LATENCY must be at least 1");
    end
    if (WORDS_PER_BANK > (1 << BANK_ADDR_WIDTH)) begin : g_addr_narrow
        $error("op_uram_drain: BANK_ADDR_WIDTH too narrow for WORDS_PER_BANK");
    end

    drain_state_e             state;
    logic [BANK_W-1:0]        bank_idx;
    logic [BANK_ADDR_WIDTH-1:0] addr_idx;
    logic [PIPE_N-1:0]        rd_pipe;
    logic [CNT_W-1:0]         fifo_count;
    logic [RESULT_WIDTH-1:0]  fifo_head0;
    logic [RESULT_WIDTH-1:0]  fifo_head1;
    logic [31:0]              beat_idx;
    int                       inflight;
    logic                     credit_ok;
    logic                     issue;
    logic                     start_accept;
    logic                     capture;
    logic                     load;
    logic                     beat_hs;
    logic                     last_addr;
    logic                     last_bank;

    assign dbg_state = state;

    // rd_pipe[0] lines up with the registered enb/addrb cycle, so the word
    // for a read is on doutb while its bit sits in rd_pipe[READ_LATENCY].
    always_comb begin
        inflight = 0;
        for (int i = 0; i < PIPE_N; i++) inflight = inflight + int'(rd_pipe[i]);
    end

    assign credit_ok    = (inflight + int'(fifo_count) + 1) <= FIFO_DEPTH;
    assign issue        = (state == ISSUE) && credit_ok;
    assign start_accept = (state == IDLE) && start;
    assign capture      = rd_pipe[READ_LATENCY];
    assign last_addr    = (addr_idx == BANK_ADDR_WIDTH'(WORDS_PER_BANK - 1));
    assign last_bank    = (bank_idx == BANK_W'(NUM_BANKS - 1));

    // Stream handshake: a beat transfers on any rising edge with tvalid && tready;
    // tvalid/tdata/tlast are registered and never change while tvalid && !tready.
    assign beat_hs = m_axis_tvalid && m_axis_tready;
    assign load    = (fifo_count >= CNT_W'(2)) && (!m_axis_tvalid || m_axis_tready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bank_idx      <= '0;
            addr_idx      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            op_uram_enb   <= '0;
            op_uram_addrb <= '0;
        end else begin
            done        <= 1'b0;
            op_uram_enb <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bank_idx <= '0;
                        addr_idx <= '0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (credit_ok) begin
                        op_uram_enb   <= NUM_BANKS'(1) << bank_idx;
                        op_uram_addrb <= addr_idx;
                        if (last_addr) begin
                            addr_idx <= '0;
                            bank_idx <= bank_idx + BANK_W'(1);
                            if (last_bank) state <= FLUSH;
                        end else begin
                            addr_idx <= addr_idx + BANK_ADDR_WIDTH'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (beat_hs && m_axis_tlast && (rd_pipe == '0) && (fifo_count == '0)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= {rd_pipe[PIPE_N-2:0], issue};
        end
    end

    op_drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RESULT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (op_uram_doutb),
        .pop_pair  (load),
        .head0     (fifo_head0),
        .head1     (fifo_head1),
        .count     (fifo_count)
    );

    // Earlier word lands in the low half of the beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            beat_idx      <= '0;
            beats_sent    <= '0;
        end else begin
            if (start_accept)  beats_sent <= '0;
            else if (beat_hs)  beats_sent <= beats_sent + 32'd1;

            if (start_accept)  beat_idx <= '0;
            else if (load)     beat_idx <= beat_idx + 32'd1;

            if (load) begin
                m_axis_tdata  <= {fifo_head1, fifo_head0};
                m_axis_tlast  <= (beat_idx == 32'(TOTAL_BEATS - 1));
                m_axis_tvalid <= 1'b1;
            end else if (beat_hs) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_op_uram_drain.sv
// Bench for op_uram_drain: URAM behavioural model, scoreboard of expected beats,
// back-pressure, mid-drain reset, ignored starts and a throughput instance.
module tb_op_uram_drain;
  import op_drain_pkg::*;

  localparam int NB     = 4;
  localparam int WPB    = 8;
  localparam int WPB2   = 64;
  localparam int RL     = 2;
  localparam int DEPTH  = 8;
  localparam int RW     = 16;
  localparam int AW     = 14;
  localparam int NBEATS = NB * WPB / 2;
  localparam int NBEATS2 = NB * WPB2 / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start, busy, done, tvalid, tready, tlast;
  logic [NB-1:0] enb;
  logic [AW-1:0] addrb;
  logic [RW-1:0] doutb;
  logic [2*RW-1:0] tdata;
  logic [31:0] beats_sent;
  drain_state_e dbg_state;

  logic t2_start, t2_busy, t2_done, t2_tvalid, t2_tready, t2_tlast;
  logic [NB-1:0] t2_enb;
  logic [AW-1:0] t2_addrb;
  logic [RW-1:0] t2_doutb;
  logic [2*RW-1:0] t2_tdata;
  logic [31:0] t2_beats_sent;
  drain_state_e t2_dbg_state;

  op_uram_drain #(.NUM_BANKS(NB), .BANK_ADDR_WIDTH(AW), .WORDS_PER_BANK(WPB),
                  .RESULT_WIDTH(RW), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .op_uram_enb(enb), .op_uram_addrb(addrb), .op_uram_doutb(doutb),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .beats_sent(beats_sent), .dbg_state(dbg_state)
  );

  op_uram_drain #(.NUM_BANKS(NB), .BANK_ADDR_WIDTH(AW), .WORDS_PER_BANK(WPB2),
                  .RESULT_WIDTH(RW), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)) dut_t2 (
    .clk(clk), .reset(reset), .start(t2_start), .busy(t2_busy), .done(t2_done),
    .op_uram_enb(t2_enb), .op_uram_addrb(t2_addrb), .op_uram_doutb(t2_doutb),
    .m_axis_tdata(t2_tdata), .m_axis_tvalid(t2_tvalid), .m_axis_tready(t2_tready),
    .m_axis_tlast(t2_tlast), .beats_sent(t2_beats_sent), .dbg_state(t2_dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bank b holds b*256+addr at every address.
  function automatic logic [RW-1:0] ref_word(input int idx, input int wpb);
    return RW'((idx / wpb) * 256 + (idx % wpb));
  endfunction

  function automatic logic [RW-1:0] uram_read(input logic [NB-1:0] e, input logic [AW-1:0] a);
    logic [RW-1:0] r;
    r = 16'hdead;
    for (int b = 0; b < NB; b++) if (e[b]) r = RW'(b * 256 + int'(a));
    return r;
  endfunction

  // URAM models: READ_LATENCY cycles from the enb/addrb cycle to valid doutb.
  logic [RW-1:0] u1_d1, u2_d1;
  always @(posedge clk) begin
    u1_d1 <= uram_read(enb, addrb);
    doutb <= u1_d1;
    u2_d1 <= uram_read(t2_enb, t2_addrb);
    t2_doutb <= u2_d1;
  end

  // ---------------- tready driver ----------------
  int ready_mode = 0;  // 0 always, 1 one-on/three-off, 2 random, 3 held low
  initial begin
    int phase;
    phase = 0;
    tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tready = 1'b1;
        1: tready = (phase % 4 == 0);
        2: tready = 1'($urandom_range(0, 1));
        default: tready = 1'b0;
      endcase
      phase++;
    end
  end

  // ---------------- scoreboard / monitor for dut ----------------
  logic [32:0] exp_q[$];
  logic [32:0] exp_b;
  int hs_in_drain = 0;
  int hs_total = 0;
  int issued_cnt = 0;
  int drain_num = 0;
  bit done_exp = 0;
  bit hold_valid = 0;
  logic [31:0] hold_data;
  logic hold_last;

  always @(negedge clk) begin
    if (reset) begin
      done_exp = 0;
      hold_valid = 0;
      hs_total = 0;
      issued_cnt = 0;
    end else begin
      int outstanding;
      check("done_pulse", done, done_exp);
      if (hold_valid) begin
        check("hold_tvalid", tvalid, 1);
        check("hold_tdata", tdata, hold_data);
        check("hold_tlast", tlast, hold_last);
      end
      if (enb != '0) issued_cnt++;
      if (busy) begin
        check("enb_onehot0", $onehot0(enb), 1);
        outstanding = issued_cnt - 2 * (hs_total + int'(tvalid));
        check("credit_bound", (outstanding >= 0) && (outstanding <= DEPTH), 1);
      end
      done_exp = tvalid && tready && tlast;
      if (tvalid && tready) begin
        check("beat_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("beat_data", tdata, exp_b[31:0]);
          check("beat_last", tlast, exp_b[32]);
        end
        if (drain_num == 1 && hs_in_drain == 0) check("beat0_const", tdata, 32'h0001_0000);
        if (drain_num == 1 && hs_in_drain == 4) check("beat4_const", tdata, 32'h0101_0100);
        hs_in_drain++;
        hs_total++;
      end
      hold_valid = tvalid && !tready;
      hold_data = tdata;
      hold_last = tlast;
    end
  end

  // ---------------- monitor for the throughput instance ----------------
  int t2_cyc = 0, t2_busy_cnt = 0, t2_issue_cnt = 0, t2_beat = 0;
  int t2_first = -1, t2_last_issue = -1;
  always @(negedge clk) begin
    if (reset) begin
      t2_busy_cnt = 0;
      t2_issue_cnt = 0;
      t2_beat = 0;
      t2_first = -1;
      t2_last_issue = -1;
    end else begin
      t2_cyc++;
      if (t2_busy) begin
        t2_busy_cnt++;
        check("t2_enb_onehot0", $onehot0(t2_enb), 1);
      end
      if (t2_enb != '0) begin
        t2_issue_cnt++;
        if (t2_first < 0) t2_first = t2_cyc;
        t2_last_issue = t2_cyc;
      end
      if (t2_tvalid && t2_tready) begin
        check("t2_beat_data", t2_tdata, {ref_word(2 * t2_beat + 1, WPB2), ref_word(2 * t2_beat, WPB2)});
        check("t2_beat_last", t2_tlast, (t2_beat == NBEATS2 - 1));
        t2_beat++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_drain_expect();
    for (int k = 0; k < NBEATS; k++)
      exp_q.push_back({(k == NBEATS - 1), ref_word(2 * k + 1, WPB), ref_word(2 * k, WPB)});
  endtask

  task automatic start_drain();
    push_drain_expect();
    hs_in_drain = 0;
    drain_num++;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_busy", busy, 1);
    check("start_beats_clr", beats_sent, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit coincide);
    bit seen;
    seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    check("done_busy_low", busy, 0);
    if (seen && coincide) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("coincide_start_ignored", busy, 0);
    end
  endtask

  task automatic wait_beats(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (hs_in_drain >= n) ok = 1;
    end
    check("beats_reached", ok, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit t2_seen;
    reset = 1'b1;
    start = 1'b0;
    t2_start = 1'b0;
    t2_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_enb", enb, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_beats", beats_sent, 0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b0;

    // Full-rate drain.
    ready_mode = 0;
    start_drain();
    wait_done(0);
    check("d1_beats_sent", beats_sent, NBEATS);
    check("d1_queue_empty", exp_q.size(), 0);

    // Sparse tready.
    ready_mode = 1;
    start_drain();
    wait_done(0);
    check("d2_beats_sent", beats_sent, NBEATS);

    // Random tready with a long stall mid-drain.
    ready_mode = 2;
    start_drain();
    wait_beats(3);
    ready_mode = 3;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_enb_idle", enb, 0);
      check("stall_tvalid", tvalid, 1);
    end
    ready_mode = 2;
    wait_done(0);
    check("d3_beats_sent", beats_sent, NBEATS);

    // Reset during the drain.
    ready_mode = 0;
    start_drain();
    wait_beats(5);
    #2 reset = 1'b1;
    #1;
    check("arst_enb", enb, 0);
    check("arst_addrb", addrb, 0);
    check("arst_tvalid", tvalid, 0);
    check("arst_tdata", tdata, 0);
    check("arst_tlast", tlast, 0);
    check("arst_busy", busy, 0);
    check("arst_beats", beats_sent, 0);
    check("arst_state", dbg_state, IDLE);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {enb != '0, tvalid, done}, 0);
    end
    start_drain();
    wait_done(0);
    check("d4_beats_sent", beats_sent, NBEATS);

    // Extra start while busy, then start coincident with done.
    start_drain();
    repeat (6) @(posedge clk);
    pulse_start();
    wait_done(1);
    repeat (40) @(negedge clk);
    check("d5_idle_after", busy, 0);
    check("d5_beats_sent", beats_sent, NBEATS);
    check("d5_queue_empty", exp_q.size(), 0);

    // Throughput on the larger instance.
    @(posedge clk); #1 t2_start = 1'b1;
    @(posedge clk); #1 t2_start = 1'b0;
    t2_seen = 0;
    for (int i = 0; i < 2000 && !t2_seen; i++) begin
      @(posedge clk); #1;
      if (t2_done) t2_seen = 1;
    end
    check("t2_done_seen", t2_seen, 1);
    @(negedge clk);
    check("t2_issue_cnt", t2_issue_cnt, NB * WPB2);
    check("t2_issue_contig", t2_last_issue - t2_first + 1, NB * WPB2);
    check("t2_busy_cycles", (t2_busy_cnt >= NB * WPB2 + RL) && (t2_busy_cnt <= NB * WPB2 + RL + 4), 1);
    check("t2_beats", t2_beat, NBEATS2);
    check("t2_beats_sent", t2_beats_sent, NBEATS2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
